reg_bank_arbiter: RTL and testbench

- Owns the five-register PWM/output-enable configuration bank and shares write access between two requesters:
  - req0: SPI-decoded writes.
  - req1: on-chip sequencer writes.
- Arbitrates round-robin and commits one write per two clocks.
- Drives the bank outputs to the output/PWM logic and emits commit and error strobes.

---
 rtl/reg_bank_arbiter.sv | 109 ++++++++++
 tb/tb_reg_bank_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter for the PWM/output-enable bank.
// One write commits every two clocks; commit and error strobes are registered.
module reg_bank_arbiter #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int FIRST_GRANT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_strobe,
  output logic              wr_src,
  output logic              err_addr,
  output logic [7:0]        commit_cnt
);

  typedef enum logic {
    IDLE,
    COMMIT
  } state_t;

  // last_id holds the requester granted last; a tie goes to the other one.
  localparam logic RST_LAST = (FIRST_GRANT == 0);

  state_t            state;
  logic              last_id;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic              h_id;
  logic              gnt0;
  logic              gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      gnt0 = req0_valid && (!req1_valid || last_id);
      gnt1 = req1_valid && (!req0_valid || !last_id);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_id         <= RST_LAST;
      h_addr          <= '0;
      h_data          <= '0;
      h_id            <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
      wr_src          <= 1'b0;
      err_addr        <= 1'b0;
      commit_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wr_strobe <= 1'b0;
          err_addr  <= 1'b0;
          if (gnt0 || gnt1) begin
            h_addr <= gnt1 ? req1_addr : req0_addr;
            h_data <= gnt1 ? req1_data : req0_data;
            h_id   <= gnt1;
            state  <= COMMIT;
          end
        end
        COMMIT: begin
          wr_src     <= h_id;
          last_id    <= h_id;
          commit_cnt <= commit_cnt + 8'd1;
          state      <= IDLE;
          wr_strobe  <= 1'b1;
          err_addr   <= 1'b0;
          case (h_addr)
            ADDR_W'(0): en_reg_out_7_0  <= h_data;
            ADDR_W'(1): en_reg_out_15_8 <= h_data;
            ADDR_W'(2): en_reg_pwm_7_0  <= h_data;
            ADDR_W'(3): en_reg_pwm_15_8 <= h_data;
            ADDR_W'(4): pwm_duty_cycle  <= h_data;
            default: begin
              wr_strobe <= 1'b0;
              err_addr  <= 1'b1;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed checks of grant order, commit timing,
// unmapped-address errors, counter wrap and reset during commit.
module tb_reg_bank_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       wr_src;
  logic       err_addr;
  logic [7:0] commit_cnt;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(
    .ADDR_W(7),
    .DATA_W(8),
    .FIRST_GRANT(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(req0_valid),
    .req0_addr(req0_addr),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr(req1_addr),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .wr_strobe(wr_strobe),
    .wr_src(wr_src),
    .err_addr(err_addr),
    .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("%s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;

    // Reset state
    do_reset();
    chk("rst_out_7_0", en_reg_out_7_0, 0);
    chk("rst_pwm_duty", pwm_duty_cycle, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_err", err_addr, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_rdy0", req0_ready, 0);

    // Single req0 write to 0x04
    req0_valid = 1'b1;
    req0_addr  = 7'h04;
    req0_data  = 8'h80;
    #1;
    chk("t1_rdy0", req0_ready, 1);
    chk("t1_rdy1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("t1_commit_rdy0", req0_ready, 0);
    chk("t1_commit_strobe", wr_strobe, 0);
    step();
    chk("t1_duty", pwm_duty_cycle, 8'h80);
    chk("t1_strobe", wr_strobe, 1);
    chk("t1_src", wr_src, 0);
    chk("t1_cnt", commit_cnt, 1);
    chk("t1_err", err_addr, 0);
    step();
    chk("t1_strobe_off", wr_strobe, 0);

    // Tie from reset: req0 first, then req1
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 7'h00;
    req0_data  = 8'hAA;
    req1_valid = 1'b1;
    req1_addr  = 7'h01;
    req1_data  = 8'h55;
    do_reset();
    chk("t2_rdy0", req0_ready, 1);
    chk("t2_rdy1", req1_ready, 0);
    step();
    #1;
    chk("t2_commit_rdy0", req0_ready, 0);
    chk("t2_commit_rdy1", req1_ready, 0);
    chk("t2_out0_pre", en_reg_out_7_0, 0);
    step();
    #1;
    chk("t2_out0", en_reg_out_7_0, 8'hAA);
    chk("t2_strobe0", wr_strobe, 1);
    chk("t2_src0", wr_src, 0);
    chk("t2_rdy1_turn", req1_ready, 1);
    chk("t2_rdy0_wait", req0_ready, 0);
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;
    chk("t2_strobe_gap", wr_strobe, 0);
    step();
    chk("t2_out1", en_reg_out_15_8, 8'h55);
    chk("t2_strobe1", wr_strobe, 1);
    chk("t2_src1", wr_src, 1);
    chk("t2_cnt", commit_cnt, 2);

    // Continuous contention: 8 alternating transfers
    req0_valid = 1'b1;
    req0_addr  = 7'h02;
    req0_data  = 8'h11;
    req1_valid = 1'b1;
    req1_addr  = 7'h03;
    req1_data  = 8'h22;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("t3_rdy0_c%0d", i), req0_ready,
          ((i % 2) == 0) && (((i / 2) % 2) == 0));
      chk($sformatf("t3_rdy1_c%0d", i), req1_ready,
          ((i % 2) == 0) && (((i / 2) % 2) == 1));
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("t3_cnt", commit_cnt, 10);
    chk("t3_pwm_7_0", en_reg_pwm_7_0, 8'h11);
    chk("t3_pwm_15_8", en_reg_pwm_15_8, 8'h22);
    chk("t3_src", wr_src, 1);

    // Unmapped address from req1
    step();
    req1_valid = 1'b1;
    req1_addr  = 7'h05;
    req1_data  = 8'hFF;
    #1;
    chk("t4_rdy1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    chk("t4_err", err_addr, 1);
    chk("t4_strobe", wr_strobe, 0);
    chk("t4_src", wr_src, 1);
    chk("t4_cnt", commit_cnt, 11);
    chk("t4_out0", en_reg_out_7_0, 8'hAA);
    chk("t4_out1", en_reg_out_15_8, 8'h55);
    chk("t4_pwm0", en_reg_pwm_7_0, 8'h11);
    chk("t4_pwm1", en_reg_pwm_15_8, 8'h22);
    chk("t4_duty", pwm_duty_cycle, 8'h00);
    step();
    chk("t4_err_off", err_addr, 0);

    // 256 back-to-back writes wrap the counter
    do_reset();
    req0_valid = 1'b1;
    req0_addr  = 7'h04;
    for (int i = 0; i < 256; i++) begin
      req0_data = 8'(i) ^ 8'h5A;
      step();
      if (i == 255) req0_valid = 1'b0;
      step();
    end
    #1;
    chk("t5_cnt_wrap", commit_cnt, 0);
    chk("t5_duty", pwm_duty_cycle, 8'hA5);
    chk("t5_strobe", wr_strobe, 1);

    // Reset during COMMIT drops the write
    step();
    req0_valid = 1'b1;
    req0_addr  = 7'h02;
    req0_data  = 8'h3C;
    step();
    req0_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("t6_pwm_in_rst", en_reg_pwm_7_0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_pwm_after", en_reg_pwm_7_0, 0);
    chk("t6_strobe", wr_strobe, 0);
    chk("t6_cnt", commit_cnt, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("t6_tie_rdy0", req0_ready, 1);
    chk("t6_tie_rdy1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
